job_sequencer: RTL and testbench
================================

Name: job_sequencer

Overview:
- PSL-side initiator for the CAPI job interface. It drives the job-control inputs of an AFU (valid, command, effective address, parities) and monitors the AFU's job outputs (running, done, error).
- Runs the mandatory sequence RESET -> wait done -> START(WED) -> wait running/done, and reports completion status to a local controller.
- Used as the PSL stand-in in AFU bring-up benches and in the loopback top level.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles to wait for done after RESET, or for running after START; fixed internal counter width 32.
- RUN_TIMEOUT_CYCLES, 0: max cycles in RUN before declaring timeout; 0 disables.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  controller requests a job
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- req_wed  in  64  work element descriptor address, captured on accept
- abort  in  1  level; in RUN, forces a RESET of the AFU
- afu_job_in  out  JobInterfaceInput  to AFU: valid, command[7:0], command_parity, address[63:0], address_parity
- afu_job_out  in  JobInterfaceOutput  from AFU: running, done, cack, error[63:0], yield
- busy  out  1  high in every state except IDLE
- complete  out  1  one-cycle pulse when a job finishes (any status)
- status  out  2  valid with complete: 0 OK, 1 AFU_ERROR, 2 TIMEOUT, 3 ABORTED; held until the next complete
- error_code  out  64  afu_job_out.error captured on the cycle done is accepted; held

Behaviour:
- Reset state (async, immediate):
  - State IDLE.
  - afu_job_in.valid=0, command=0, address=0.
  - busy=0, complete=0, status=0, error_code=0, timer=0.
- Command encodings:
  - RESET=8'h80, START=8'h90, TIMEBASE=8'h42 (TIMEBASE is never issued).
- Parity:
  - Odd parity. command_parity = ~^command; address_parity = ~^address.
  - Both are registered with their data, so they are valid in the same cycle as valid.
- Issue rule:
  - afu_job_in.valid is high for exactly one cycle per command.
  - command and address hold their values until the next issue.
- States:
  - IDLE:
    - req_ready=1.
    - On accept, latch req_wed and go to RST_ISSUE.
  - RST_ISSUE:
    - Drive valid=1, command=RESET, address=0; clear timer.
    - Go to RST_WAIT next cycle.
  - RST_WAIT:
    - done=1: go to START_ISSUE (abort path: go to FINISH with ABORTED).
    - timer reaches TIMEOUT_CYCLES-1: go to FINISH with TIMEOUT.
  - START_ISSUE:
    - Drive valid=1, command=START, address=latched WED; clear timer.
    - Go to START_WAIT.
  - START_WAIT:
    - running=1: go to RUN.
    - done=1: go to FINISH directly (zero-length job).
    - Timeout as in RST_WAIT.
  - RUN:
    - done=1: go to FINISH with OK if error==0, else AFU_ERROR.
    - abort=1: set abort flag, go to RST_ISSUE.
    - RUN_TIMEOUT expiry: go to FINISH with TIMEOUT.
  - FINISH:
    - Pulse complete for one cycle, update status.
    - Return to IDLE; req_ready rises the cycle after complete.
- Priority in the same cycle: done > abort > timeout.
- done sampling:
  - done is sampled only in the WAIT/RUN states.
  - done in an ISSUE cycle or in IDLE is ignored.
- Running transitions:
  - running deasserting in RUN without done is ignored.
  - cack and yield are ignored.
- Latency: accept to RESET valid is 1 cycle; done to START valid is 1 cycle; done to complete is 1 cycle.
- Abort outside RUN has no effect.
- Reset mid-job: state returns to IDLE asynchronously; no complete pulse is generated.

Decomposition:
- The CAPI package already holds JobInterfaceInput/Output and the RESET command. Add to it:
  - START and TIMEBASE command constants.
  - A JobStatus enum (OK, AFU_ERROR, TIMEOUT, ABORTED).
  - An odd_parity function (8- and 64-bit use).
- Sub-module job_timer:
  - Loadable 32-bit up-counter with clear and an expire compare against a runtime limit.
  - Instantiated once and shared by the WAIT and RUN states.

Test Plan:
- Nominal job:
  - Stimulus: req with WED 64'h0000_1000_0000_0040; AFU model answers done 3 cycles after RESET, running 2 cycles after START, done+error=0 10 cycles later.
  - Required: exactly one RESET pulse with parity 0 (8'h80 has odd weight), then START with address 64'h...0040; complete pulse with status OK.
- AFU error:
  - Stimulus: done with error=64'hDEAD.
  - Required: status AFU_ERROR, error_code 64'hDEAD held after complete.
- Reset timeout:
  - Stimulus: TIMEOUT_CYCLES=16, AFU never asserts done.
  - Required: complete 17-18 cycles after the RESET issue, status TIMEOUT, no START ever issued.
- Abort:
  - Stimulus: abort asserted in RUN.
  - Required: second RESET issued next cycle; after done, status ABORTED.
  - Stimulus variant: done and abort in the same cycle.
  - Required: status OK, no second RESET.
- Mid-job reset:
  - Stimulus: assert reset during START_WAIT.
  - Required: afu_job_in.valid=0 and busy=0 immediately, no complete pulse; a fresh request then runs normally.
- Parity sweep:
  - Stimulus: WED values 0, all-ones, and 64'h1.
  - Required: address_parity 1, 1, 0 respectively.

Source files
------------

// File: rtl/job_sequencer_pkg.sv
// CAPI job interface types, command encodings and helpers shared by the
// job sequencer and its timer.
package job_sequencer_pkg;

    // Signals driven from the PSL side into the AFU job-control port.
    typedef struct packed {
        logic        valid;
        logic [7:0]  command;
        logic        command_parity;
        logic [63:0] address;
        logic        address_parity;
    } JobInterfaceInput;

    // Signals returned by the AFU on its job-status port.
    typedef struct packed {
        logic        running;
        logic        done;
        logic        cack;
        logic [63:0] error;
        logic        yield;
    } JobInterfaceOutput;

    // Job-control command encodings.
    localparam logic [7:0] CMD_RESET    = 8'h80;
    localparam logic [7:0] CMD_START    = 8'h90;
    localparam logic [7:0] CMD_TIMEBASE = 8'h42;

    // Completion status reported to the local controller.
    typedef enum logic [1:0] {
        STATUS_OK        = 2'd0,
        STATUS_AFU_ERROR = 2'd1,
        STATUS_TIMEOUT   = 2'd2,
        STATUS_ABORTED   = 2'd3
    } JobStatus;

    // Odd parity bit: set so the data plus parity carries an odd number of
    // ones. Narrower values are zero-extended, which does not change parity.
    function automatic logic odd_parity(input logic [63:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/job_sequencer_timer.sv
// Shared 32-bit up-counter used for the reset/start wait timeouts and the
// optional run-time limit. Clear wins over load, load wins over counting.
module job_timer
    import job_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        enable,
    input  logic [31:0] limit,
    output logic [31:0] count,
    output logic        expired
);

    // Counter register: clear, load, then count while enabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

    assign expired = (count == limit);

endmodule

// File: rtl/job_sequencer.sv
// PSL-side job initiator: resets the AFU, starts it with the captured WED,
// waits for completion and reports a status to the local controller.
module job_sequencer
    import job_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES     = 1024,
    parameter int RUN_TIMEOUT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_wed,
    input  logic              abort,
    output JobInterfaceInput  afu_job_in,
    input  JobInterfaceOutput afu_job_out,
    output logic              busy,
    output logic              complete,
    output logic [1:0]        status,
    output logic [63:0]       error_code
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] RST_ISSUE   = 3'd1;
    localparam logic [2:0] RST_WAIT    = 3'd2;
    localparam logic [2:0] START_ISSUE = 3'd3;
    localparam logic [2:0] START_WAIT  = 3'd4;
    localparam logic [2:0] RUN         = 3'd5;
    localparam logic [2:0] FINISH      = 3'd6;

    localparam logic [31:0] WAIT_LIMIT     = 32'(TIMEOUT_CYCLES - 1);
    localparam logic        RUN_TIMEOUT_EN = (RUN_TIMEOUT_CYCLES > 0);
    localparam logic [31:0] RUN_LIMIT      =
        (RUN_TIMEOUT_CYCLES > 0) ? 32'(RUN_TIMEOUT_CYCLES - 1) : 32'd0;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [63:0]      wed_q;
    logic             abort_flag;
    logic             set_abort;
    logic             capture_error;
    logic             load_status;
    JobStatus         finish_status;
    JobStatus         status_q;
    JobInterfaceInput job_in_q;

    logic             timer_clear;
    logic             timer_enable;
    logic [31:0]      timer_limit;
    logic [31:0]      timer_count;
    logic             timer_expired;
    logic             unused_signals;

    // The timer restarts on every state change, so each wait or run phase
    // measures its own duration from zero.
    assign timer_clear  = (state != next_state);
    assign timer_enable = (state == RST_WAIT) || (state == START_WAIT) || (state == RUN);
    assign timer_limit  = (state == RUN) ? RUN_LIMIT : WAIT_LIMIT;

    job_timer u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (timer_clear),
        .load       (1'b0),
        .load_value (32'd0),
        .enable     (timer_enable),
        .limit      (timer_limit),
        .count      (timer_count),
        .expired    (timer_expired)
    );

    // Next-state decision; done beats abort, abort beats timeout.
    always_comb begin
        next_state    = state;
        set_abort     = 1'b0;
        capture_error = 1'b0;
        load_status   = 1'b0;
        finish_status = STATUS_OK;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = RST_ISSUE;
                end
            end
            RST_ISSUE: begin
                next_state = RST_WAIT;
            end
            RST_WAIT: begin
                if (afu_job_out.done) begin
                    if (abort_flag) begin
                        next_state    = FINISH;
                        capture_error = 1'b1;
                        load_status   = 1'b1;
                        finish_status = STATUS_ABORTED;
                    end else begin
                        next_state = START_ISSUE;
                    end
                end else if (timer_expired) begin
                    next_state    = FINISH;
                    load_status   = 1'b1;
                    finish_status = STATUS_TIMEOUT;
                end
            end
            START_ISSUE: begin
                next_state = START_WAIT;
            end
            START_WAIT: begin
                if (afu_job_out.done) begin
                    next_state    = FINISH;
                    capture_error = 1'b1;
                    load_status   = 1'b1;
                    finish_status = (afu_job_out.error == '0) ? STATUS_OK : STATUS_AFU_ERROR;
                end else if (afu_job_out.running) begin
                    next_state = RUN;
                end else if (timer_expired) begin
                    next_state    = FINISH;
                    load_status   = 1'b1;
                    finish_status = STATUS_TIMEOUT;
                end
            end
            RUN: begin
                if (afu_job_out.done) begin
                    next_state    = FINISH;
                    capture_error = 1'b1;
                    load_status   = 1'b1;
                    finish_status = (afu_job_out.error == '0) ? STATUS_OK : STATUS_AFU_ERROR;
                end else if (abort) begin
                    next_state = RST_ISSUE;
                    set_abort  = 1'b1;
                end else if (RUN_TIMEOUT_EN && timer_expired) begin
                    next_state    = FINISH;
                    load_status   = 1'b1;
                    finish_status = STATUS_TIMEOUT;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register and per-job bookkeeping (WED, abort flag).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wed_q      <= '0;
            abort_flag <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_valid) begin
                wed_q      <= req_wed;
                abort_flag <= 1'b0;
            end else if (set_abort) begin
                abort_flag <= 1'b1;
            end
        end
    end

    // Registered job-control outputs: a command is loaded on entry to an
    // issue state so valid, data and parity all appear in that state's cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            job_in_q.valid          <= 1'b0;
            job_in_q.command        <= '0;
            job_in_q.command_parity <= odd_parity(64'd0);
            job_in_q.address        <= '0;
            job_in_q.address_parity <= odd_parity(64'd0);
        end else begin
            job_in_q.valid <= 1'b0;
            if (next_state == RST_ISSUE) begin
                job_in_q.valid          <= 1'b1;
                job_in_q.command        <= CMD_RESET;
                job_in_q.command_parity <= odd_parity(64'(CMD_RESET));
                job_in_q.address        <= '0;
                job_in_q.address_parity <= odd_parity(64'd0);
            end else if (next_state == START_ISSUE) begin
                job_in_q.valid          <= 1'b1;
                job_in_q.command        <= CMD_START;
                job_in_q.command_parity <= odd_parity(64'(CMD_START));
                job_in_q.address        <= wed_q;
                job_in_q.address_parity <= odd_parity(wed_q);
            end
        end
    end

    // Completion status and AFU error word, held until the next job ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q   <= STATUS_OK;
            error_code <= '0;
        end else begin
            if (load_status) begin
                status_q <= finish_status;
            end
            if (capture_error) begin
                error_code <= afu_job_out.error;
            end
        end
    end

    assign afu_job_in = job_in_q;
    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign complete   = (state == FINISH);
    assign status     = status_q;

    assign unused_signals = ^{afu_job_out.cack, afu_job_out.yield, timer_count};

endmodule

// File: tb/tb_job_sequencer.sv
// Directed bench for job_sequencer: drives a scripted AFU on the falling
// edge and checks outputs against hand-computed values.
module tb_job_sequencer;
    import job_sequencer_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [63:0]       req_wed;
    logic              abort;
    JobInterfaceInput  afu_job_in;
    JobInterfaceOutput afu_job_out;
    logic              busy;
    logic              complete;
    logic [1:0]        status;
    logic [63:0]       error_code;

    int tests_run    = 0;
    int tests_failed = 0;
    int reset_issues = 0;
    int start_issues = 0;
    int completes    = 0;

    job_sequencer #(
        .TIMEOUT_CYCLES     (16),
        .RUN_TIMEOUT_CYCLES (0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wed     (req_wed),
        .abort       (abort),
        .afu_job_in  (afu_job_in),
        .afu_job_out (afu_job_out),
        .busy        (busy),
        .complete    (complete),
        .status      (status),
        .error_code  (error_code)
    );

    always #5 clock = ~clock;

    // Count issued commands and completion pulses just after each edge.
    always @(posedge clock) begin
        #1;
        if (afu_job_in.valid && afu_job_in.command == 8'h80) reset_issues++;
        if (afu_job_in.valid && afu_job_in.command == 8'h90) start_issues++;
        if (complete) completes++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Present one request for a single cycle; returns in the RESET issue cycle.
    task automatic applyStimulus(input logic [63:0] wed);
        req_valid = 1'b1;
        req_wed   = wed;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Request, answer RESET with done after 3 cycles and START with running
    // after 2; returns on the first RUN cycle with running held high.
    task automatic doHandshake(input logic [63:0] wed);
        applyStimulus(wed);
        tick(3);
        afu_job_out.done = 1'b1;
        tick(1);
        afu_job_out.done = 1'b0;
        tick(2);
        afu_job_out.running = 1'b1;
        tick(1);
    endtask

    // Signal done with the given error word; returns in the FINISH cycle.
    task automatic finishWith(input logic [63:0] err);
        afu_job_out.done  = 1'b1;
        afu_job_out.error = err;
        tick(1);
        afu_job_out.done    = 1'b0;
        afu_job_out.running = 1'b0;
        afu_job_out.error   = '0;
    endtask

    initial begin
        int r0;
        int s0;
        int c0;
        int seen;
        logic [63:0] sweep_wed [3];
        logic        sweep_par [3];

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_wed     = '0;
        abort       = 1'b0;
        afu_job_out = '0;
        tick(2);

        checkOutput("rst_valid",    64'(afu_job_in.valid),   64'd0);
        checkOutput("rst_command",  64'(afu_job_in.command), 64'd0);
        checkOutput("rst_address",  afu_job_in.address,      64'd0);
        checkOutput("rst_busy",     64'(busy),               64'd0);
        checkOutput("rst_complete", 64'(complete),           64'd0);
        checkOutput("rst_status",   64'(status),             64'd0);
        checkOutput("rst_errcode",  error_code,              64'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("idle_ready", 64'(req_ready), 64'd1);

        // Nominal job
        r0 = reset_issues; s0 = start_issues; c0 = completes;
        applyStimulus(64'h0000_1000_0000_0040);
        checkOutput("nom_rst_valid",  64'(afu_job_in.valid),          64'd1);
        checkOutput("nom_rst_cmd",    64'(afu_job_in.command),        64'h80);
        checkOutput("nom_rst_cpar",   64'(afu_job_in.command_parity), 64'd0);
        checkOutput("nom_rst_addr",   afu_job_in.address,             64'd0);
        checkOutput("nom_busy",       64'(busy),                      64'd1);
        checkOutput("nom_ready_low",  64'(req_ready),                 64'd0);
        tick(3);
        afu_job_out.done = 1'b1;
        tick(1);
        afu_job_out.done = 1'b0;
        checkOutput("nom_start_valid", 64'(afu_job_in.valid),          64'd1);
        checkOutput("nom_start_cmd",   64'(afu_job_in.command),        64'h90);
        checkOutput("nom_start_cpar",  64'(afu_job_in.command_parity), 64'd1);
        checkOutput("nom_start_addr",  afu_job_in.address,             64'h0000_1000_0000_0040);
        checkOutput("nom_start_apar",  64'(afu_job_in.address_parity), 64'd1);
        tick(1);
        checkOutput("nom_valid_pulse", 64'(afu_job_in.valid),          64'd0);
        checkOutput("nom_addr_hold",   afu_job_in.address,             64'h0000_1000_0000_0040);
        tick(1);
        afu_job_out.running = 1'b1;
        tick(10);
        finishWith(64'd0);
        checkOutput("nom_complete", 64'(complete), 64'd1);
        checkOutput("nom_status",   64'(status),   64'd0);
        tick(1);
        checkOutput("nom_complete_pulse", 64'(complete),  64'd0);
        checkOutput("nom_ready_back",     64'(req_ready), 64'd1);
        checkOutput("nom_reset_count",    64'(reset_issues - r0), 64'd1);
        checkOutput("nom_start_count",    64'(start_issues - s0), 64'd1);
        checkOutput("nom_complete_count", 64'(completes - c0),    64'd1);

        // AFU error
        doHandshake(64'h0000_0000_0000_2000);
        tick(3);
        finishWith(64'hDEAD);
        checkOutput("err_complete", 64'(complete), 64'd1);
        checkOutput("err_status",   64'(status),   64'd1);
        checkOutput("err_code",     error_code,    64'hDEAD);
        tick(3);
        checkOutput("err_code_held",   error_code, 64'hDEAD);
        checkOutput("err_status_held", 64'(status), 64'd1);

        // Reset timeout: AFU never answers RESET
        s0 = start_issues;
        applyStimulus(64'h0000_0000_0000_3000);
        seen = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (complete) begin
                seen = i;
                break;
            end
        end
        checkOutput("tmo_latency_17_18", 64'((seen >= 17) && (seen <= 18)), 64'd1);
        checkOutput("tmo_status",        64'(status),            64'd2);
        checkOutput("tmo_no_start",      64'(start_issues - s0), 64'd0);
        tick(1);

        // Abort in RUN
        r0 = reset_issues; s0 = start_issues;
        doHandshake(64'h0000_0000_0000_4000);
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        afu_job_out.running = 1'b0;
        checkOutput("abt_reset_valid", 64'(afu_job_in.valid),   64'd1);
        checkOutput("abt_reset_cmd",   64'(afu_job_in.command), 64'h80);
        checkOutput("abt_reset_addr",  afu_job_in.address,      64'd0);
        tick(2);
        finishWith(64'd0);
        checkOutput("abt_complete",    64'(complete),          64'd1);
        checkOutput("abt_status",      64'(status),            64'd3);
        checkOutput("abt_reset_count", 64'(reset_issues - r0), 64'd2);
        checkOutput("abt_start_count", 64'(start_issues - s0), 64'd1);
        tick(1);

        // done and abort in the same RUN cycle
        r0 = reset_issues;
        doHandshake(64'h0000_0000_0000_5000);
        tick(2);
        abort = 1'b1;
        finishWith(64'd0);
        abort = 1'b0;
        checkOutput("dab_complete", 64'(complete), 64'd1);
        checkOutput("dab_status",   64'(status),   64'd0);
        tick(1);
        checkOutput("dab_no_reset",    64'(afu_job_in.valid),  64'd0);
        checkOutput("dab_reset_count", 64'(reset_issues - r0), 64'd1);

        // Reset during START_WAIT
        c0 = completes;
        applyStimulus(64'h0000_0000_0000_6000);
        tick(3);
        afu_job_out.done = 1'b1;
        tick(1);
        afu_job_out.done = 1'b0;
        tick(1);
        #1 reset = 1'b1;
        #1;
        checkOutput("mrst_valid", 64'(afu_job_in.valid), 64'd0);
        checkOutput("mrst_busy",  64'(busy),             64'd0);
        @(negedge clock);
        reset = 1'b0;
        tick(3);
        checkOutput("mrst_no_complete", 64'(completes - c0), 64'd0);
        doHandshake(64'h0000_0000_0000_7000);
        tick(2);
        finishWith(64'd0);
        checkOutput("mrst_fresh_complete", 64'(complete), 64'd1);
        checkOutput("mrst_fresh_status",   64'(status),   64'd0);
        tick(1);

        // Address parity sweep using zero-length jobs
        sweep_wed[0] = 64'd0;               sweep_par[0] = 1'b1;
        sweep_wed[1] = 64'hFFFF_FFFF_FFFF_FFFF; sweep_par[1] = 1'b1;
        sweep_wed[2] = 64'd1;               sweep_par[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(sweep_wed[k]);
            tick(3);
            afu_job_out.done = 1'b1;
            tick(1);
            afu_job_out.done = 1'b0;
            checkOutput($sformatf("par_valid_%0d", k), 64'(afu_job_in.valid),          64'd1);
            checkOutput($sformatf("par_addr_%0d", k),  afu_job_in.address,             sweep_wed[k]);
            checkOutput($sformatf("par_apar_%0d", k),  64'(afu_job_in.address_parity), 64'(sweep_par[k]));
            tick(1);
            finishWith(64'd0);
            checkOutput($sformatf("par_zero_len_%0d", k), 64'(complete), 64'd1);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
